// File: rtl/alu_sum_accumulator_if.sv
// Handshake bundle between the sum accumulator and its upstream/downstream stages.
// The master side drives start/count/beats and consumes the result; the slave side is the accumulator.
interface alu_sum_accumulator_if #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [7:0]       in_sum;
  logic             in_ready;
  logic             out_valid;
  logic [ACC_W-1:0] out_acc;
  logic             out_overflow;
  logic             out_ready;
  logic             busy;

  modport master (
    output start, count, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_overflow, busy
  );

  modport slave (
    input  start, count, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_overflow, busy
  );
endinterface

// File: rtl/alu_sum_accumulator.sv
// Accumulates a start-specified number of 8-bit adder sums into a saturating ACC_W-bit total
// and presents the result with a valid/ready handshake.
module alu_sum_accumulator #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_sum_accumulator_if.slave  acc_if
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  if (ACC_W < 9 || ACC_W > 16) begin : g_bad_acc_w
    $error("ACC_W must be within 9..16");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic             out_ovf_q;
  logic             busy_q;

  logic [SUM_W-1:0] sum_raw_c;
  logic             sat_c;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;
  logic             beat_c;

  // Saturating next accumulator value for the beat currently offered.
  always_comb begin
    sum_raw_c = SUM_W'(acc_q) + SUM_W'(acc_if.in_sum);
    sat_c     = sum_raw_c[ACC_W];
    acc_d     = sat_c ? ACC_MAX : sum_raw_c[ACC_W-1:0];
    ovf_d     = ovf_q | sat_c;
    beat_c    = acc_if.in_valid && in_ready_q && (remaining_q != '0);
  end

  // Control FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc_if.start) begin
            remaining_q <= acc_if.count;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (acc_if.count != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_acc_q   <= '0;
              out_ovf_q   <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (beat_c) begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_acc_q   <= acc_d;
              out_ovf_q   <= ovf_d;
            end
          end
        end
        DONE: begin
          // Returning to IDLE first means a start seen on this edge is not taken.
          if (acc_if.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_if.in_ready     = in_ready_q;
  assign acc_if.out_valid    = out_valid_q;
  assign acc_if.out_acc      = out_acc_q;
  assign acc_if.out_overflow = out_ovf_q;
  assign acc_if.busy         = busy_q;

endmodule

// File: tb/tb_alu_sum_accumulator.sv
// Scenario bench for alu_sum_accumulator: a 12-bit instance for most runs and a 9-bit
// instance for saturation; expected results are queued at stimulus time and popped at output.
module tb_alu_sum_accumulator;

  typedef struct {
    int unsigned acc;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  alu_sum_accumulator_if #(.ACC_W(12), .CNT_W(4)) a ();
  alu_sum_accumulator_if #(.ACC_W(9),  .CNT_W(4)) b ();

  alu_sum_accumulator #(.ACC_W(12), .CNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .acc_if(a.slave));
  alu_sum_accumulator #(.ACC_W(9),  .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .acc_if(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference saturating accumulation step.
  function automatic exp_t model_step(input exp_t e, input int unsigned s, input int unsigned w);
    exp_t r;
    int unsigned mx;
    mx = (1 << w) - 1;
    r = e;
    if (e.acc + s > mx) begin
      r.acc = mx;
      r.ovf = 1'b1;
    end else begin
      r.acc = e.acc + s;
    end
    return r;
  endfunction

  task automatic idle_inputs();
    a.start = 1'b0; a.count = '0; a.in_valid = 1'b0; a.in_sum = '0; a.out_ready = 1'b0;
    b.start = 1'b0; b.count = '0; b.in_valid = 1'b0; b.in_sum = '0; b.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({a.in_ready, a.out_valid, a.out_overflow, a.busy} !== 4'b0 || a.out_acc !== 12'd0)
      $display("FAIL reset_a: got rdy=%b vld=%b ovf=%b busy=%b acc=%0d required all 0",
               a.in_ready, a.out_valid, a.out_overflow, a.busy, a.out_acc);
    else n_pass++;
    n_checks++;
    if ({b.in_ready, b.out_valid, b.out_overflow, b.busy} !== 4'b0 || b.out_acc !== 9'd0)
      $display("FAIL reset_b: got rdy=%b vld=%b ovf=%b busy=%b acc=%0d required all 0",
               b.in_ready, b.out_valid, b.out_overflow, b.busy, b.out_acc);
    else n_pass++;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int   sums[3];
    exp_t e;
    int   waited;
    sums = '{5, 10, 30};
    e = '{acc: 0, ovf: 1'b0};
    foreach (sums[i]) e = model_step(e, sums[i], 12);
    sb.push_back(e);
    a.start = 1'b1; a.count = 4'd3; a.out_ready = 1'b1;
    tick();
    a.start = 1'b0;
    n_checks++;
    if (a.in_ready !== 1'b1 || a.busy !== 1'b1)
      $display("FAIL basic_accum_state: got in_ready=%b busy=%b required 1 1", a.in_ready, a.busy);
    else n_pass++;
    foreach (sums[i]) begin
      a.in_valid = 1'b1; a.in_sum = 8'(sums[i]);
      tick();
    end
    a.in_valid = 1'b0;
    waited = 0;
    n_checks++;
    if (a.out_valid !== 1'b1)
      $display("FAIL basic_latency: got out_valid=%b required 1 one cycle after last beat", a.out_valid);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (32'(a.out_acc) !== e.acc || a.out_overflow !== e.ovf)
      $display("FAIL basic_result: got acc=%0d ovf=%b required acc=%0d ovf=%b",
               a.out_acc, a.out_overflow, e.acc, e.ovf);
    else n_pass++;
    tick();
    n_checks++;
    if (a.out_valid !== 1'b0 || a.busy !== 1'b0 || a.in_ready !== 1'b0)
      $display("FAIL basic_idle: got vld=%b busy=%b rdy=%b required 0 0 0",
               a.out_valid, a.busy, a.in_ready);
    else n_pass++;
    n_checks++;
    if (a.out_acc !== 12'd45)
      $display("FAIL basic_hold_idle: got acc=%0d required 45", a.out_acc);
    else n_pass++;
    a.out_ready = 1'b0;
  endtask

  task automatic test_toggle();
    logic pat[7];
    exp_t e;
    int   rem;
    int   beats;
    int   busy_bad;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    e = '{acc: 0, ovf: 1'b0};
    rem = 4; beats = 0; busy_bad = 0;
    a.start = 1'b1; a.count = 4'd4; a.out_ready = 1'b0;
    tick();
    a.start = 1'b0;
    foreach (pat[i]) begin
      if (a.busy !== 1'b1) busy_bad++;
      if (pat[i] && rem > 0) begin
        e = model_step(e, 7, 12);
        rem--;
        beats++;
      end
      a.in_valid = pat[i]; a.in_sum = 8'd7;
      tick();
    end
    sb.push_back(e);
    // Surplus beats while in DONE must not be accumulated.
    a.in_valid = 1'b1;
    tick(); tick();
    a.in_valid = 1'b0;
    n_checks++;
    if (busy_bad != 0 || a.busy !== 1'b1)
      $display("FAIL toggle_busy: got %0d low-busy cycles busy_now=%b required 0 and 1", busy_bad, a.busy);
    else n_pass++;
    e = sb.pop_front();
    n_checks++;
    if (a.out_valid !== 1'b1 || 32'(a.out_acc) !== e.acc || beats != 4)
      $display("FAIL toggle_result: got vld=%b acc=%0d required vld=1 acc=%0d", a.out_valid, a.out_acc, e.acc);
    else n_pass++;
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    n_checks++;
    if (a.busy !== 1'b0 || a.out_valid !== 1'b0)
      $display("FAIL toggle_handshake: got busy=%b vld=%b required 0 0", a.busy, a.out_valid);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int   sums[3];
    exp_t e;
    sums = '{255, 255, 30};
    e = '{acc: 0, ovf: 1'b0};
    foreach (sums[i]) e = model_step(e, sums[i], 9);
    sb.push_back(e);
    b.start = 1'b1; b.count = 4'd3; b.out_ready = 1'b1;
    tick();
    b.start = 1'b0;
    foreach (sums[i]) begin
      b.in_valid = 1'b1; b.in_sum = 8'(sums[i]);
      tick();
    end
    b.in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (b.out_valid !== 1'b1 || 32'(b.out_acc) !== e.acc || b.out_overflow !== e.ovf)
      $display("FAIL sat_result: got vld=%b acc=%0d ovf=%b required vld=1 acc=%0d ovf=%b",
               b.out_valid, b.out_acc, b.out_overflow, e.acc, e.ovf);
    else n_pass++;
    tick();
    n_checks++;
    if (b.out_valid !== 1'b0 || b.out_acc !== 9'd511 || b.out_overflow !== 1'b1)
      $display("FAIL sat_hold_idle: got vld=%b acc=%0d ovf=%b required 0 511 1",
               b.out_valid, b.out_acc, b.out_overflow);
    else n_pass++;
    // A zero-length run must clear the sticky flag and the total.
    b.start = 1'b1; b.count = 4'd0;
    tick();
    b.start = 1'b0;
    n_checks++;
    if (b.out_valid !== 1'b1 || b.out_acc !== 9'd0 || b.out_overflow !== 1'b0)
      $display("FAIL sat_zero_run: got vld=%b acc=%0d ovf=%b required 1 0 0",
               b.out_valid, b.out_acc, b.out_overflow);
    else n_pass++;
    tick();
    b.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    exp_t e;
    int   bad;
    e = '{acc: 0, ovf: 1'b0};
    e = model_step(e, 20, 12);
    e = model_step(e, 20, 12);
    sb.push_back(e);
    a.start = 1'b1; a.count = 4'd2; a.out_ready = 1'b0;
    tick();
    a.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a.in_valid = 1'b1; a.in_sum = 8'd20;
      tick();
    end
    a.in_valid = 1'b0;
    e = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (a.out_valid !== 1'b1 || 32'(a.out_acc) !== e.acc || a.out_overflow !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL stall_hold: got %0d unstable cycles (acc=%0d vld=%b) required 0 with acc=%0d",
               bad, a.out_acc, a.out_valid, e.acc);
    else n_pass++;
    n_checks++;
    if (a.out_valid !== 1'b1 || a.busy !== 1'b1)
      $display("FAIL stall_still_done: got vld=%b busy=%b required 1 1", a.out_valid, a.busy);
    else n_pass++;
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    n_checks++;
    if (a.out_valid !== 1'b0 || a.busy !== 1'b0)
      $display("FAIL stall_release: got vld=%b busy=%b required 0 0", a.out_valid, a.busy);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    a.start = 1'b1; a.count = 4'd3;
    tick();
    a.start = 1'b0;
    a.in_valid = 1'b1; a.in_sum = 8'd4;
    tick();
    a.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a.in_ready, a.out_valid, a.out_overflow, a.busy} !== 4'b0 || a.out_acc !== 12'd0)
      $display("FAIL midreset_async: got rdy=%b vld=%b ovf=%b busy=%b acc=%0d required all 0",
               a.in_ready, a.out_valid, a.out_overflow, a.busy, a.out_acc);
    else n_pass++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    e = model_step('{acc: 0, ovf: 1'b0}, 9, 12);
    sb.push_back(e);
    a.start = 1'b1; a.count = 4'd1; a.out_ready = 1'b1;
    tick();
    a.start = 1'b0;
    n_checks++;
    if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0)
      $display("FAIL midreset_first_start: got rdy=%b vld=%b required 1 0", a.in_ready, a.out_valid);
    else n_pass++;
    a.in_valid = 1'b1; a.in_sum = 8'd9;
    tick();
    a.in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (a.out_valid !== 1'b1 || 32'(a.out_acc) !== e.acc)
      $display("FAIL midreset_rerun: got vld=%b acc=%0d required 1 %0d", a.out_valid, a.out_acc, e.acc);
    else n_pass++;
    tick();
    a.out_ready = 1'b0;
  endtask

  task automatic test_count_zero();
    a.start = 1'b1; a.count = 4'd0; a.out_ready = 1'b0;
    tick();
    a.start = 1'b0;
    n_checks++;
    if (a.out_valid !== 1'b1 || a.out_acc !== 12'd0 || a.out_overflow !== 1'b0 || a.in_ready !== 1'b0)
      $display("FAIL zero_count: got vld=%b acc=%0d ovf=%b rdy=%b required 1 0 0 0",
               a.out_valid, a.out_acc, a.out_overflow, a.in_ready);
    else n_pass++;
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    exp_t e;
    e = '{acc: 0, ovf: 1'b0};
    e = model_step(e, 3, 12);
    e = model_step(e, 4, 12);
    sb.push_back(e);
    a.start = 1'b1; a.count = 4'd2;
    tick();
    // Keep start asserted with a different count throughout the run.
    a.count = 4'd5;
    a.in_valid = 1'b1; a.in_sum = 8'd3;
    tick();
    a.in_sum = 8'd4;
    tick();
    a.in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (a.out_valid !== 1'b1 || 32'(a.out_acc) !== e.acc)
      $display("FAIL start_in_accum: got vld=%b acc=%0d required 1 %0d", a.out_valid, a.out_acc, e.acc);
    else n_pass++;
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    n_checks++;
    if (a.busy !== 1'b0 || a.in_ready !== 1'b0 || a.out_valid !== 1'b0)
      $display("FAIL start_on_handshake: got busy=%b rdy=%b vld=%b required 0 0 0",
               a.busy, a.in_ready, a.out_valid);
    else n_pass++;
    tick();
    a.start = 1'b0;
    n_checks++;
    if (a.busy !== 1'b1 || a.in_ready !== 1'b1)
      $display("FAIL start_after_idle: got busy=%b rdy=%b required 1 1", a.busy, a.in_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      a.in_valid = 1'b1; a.in_sum = 8'd1;
      tick();
    end
    a.in_valid = 1'b0;
    n_checks++;
    if (a.out_valid !== 1'b1 || a.out_acc !== 12'd5)
      $display("FAIL start_after_idle_result: got vld=%b acc=%0d required 1 5", a.out_valid, a.out_acc);
    else n_pass++;
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_toggle();
    test_saturate();
    test_stall();
    test_count_zero();
    test_start_ignored();
    test_mid_reset();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
